// File: rtl/ram8_bist_pkg.sv
// ram8_bist_pkg
// Shared definitions for the RAM8 pattern-test engine:
//   - default data width, address width and phase-0 test pattern
//   - FSM state encoding (IDLE=0, W0=1, R0=2, W1=3, R1=4, DONE=5)
//   - helper that tells whether a state belongs to the busy window
// Optional feature macro used by ram8_bist: RAM8_BIST_STOP_ON_FAIL_EN.
package ram8_bist_pkg;

  localparam int          WIDTH_DEF   = 16;
  localparam int          ADDR_W_DEF  = 3;
  localparam logic [15:0] PATTERN_DEF = 16'h5555;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    R0   = 3'd2,
    W1   = 3'd3,
    R1   = 3'd4,
    DONE = 3'd5
  } state_t;

  // W0..R1 are the 32 cycles during which the RAM is being exercised.
  function automatic logic is_busy_state(input state_t s);
    return (s == W0) || (s == R0) || (s == W1) || (s == R1);
  endfunction

endpackage

// File: rtl/ram8_bist_if.sv
// ram8_bist_if
// Port bundle between the test engine (master) and one RAM8 (slave).
//   mem_in      : write data, master -> RAM
//   mem_load    : write strobe, master -> RAM
//   mem_address : word address, master -> RAM
//   mem_out     : read data, RAM -> master
// Protocol: there is no valid/ready pair. mem_load=1 during a cycle writes
// mem_in into word mem_address at the rising edge that ends the cycle;
// mem_out is a combinational read of the currently addressed word and is
// always valid, so no back-pressure exists in either direction.
interface ram8_bist_if
  import ram8_bist_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [WIDTH-1:0]  mem_in;
  logic              mem_load;
  logic [ADDR_W-1:0] mem_address;
  logic [WIDTH-1:0]  mem_out;

  modport master (
    output mem_in,
    output mem_load,
    output mem_address,
    input  mem_out
  );

  modport slave (
    input  mem_in,
    input  mem_load,
    input  mem_address,
    output mem_out
  );

endinterface

// File: rtl/ram8_bist_addr_ctr.sv
// ram8_bist_addr_ctr
// Word-address counter for the RAM8 test engine.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (addr -> 0)
//   clr   : synchronous clear to 0, has priority over en
//   en    : increment by one per cycle, wrapping at the top address
//   addr  : current address (registered)
//   tc    : terminal count, high while addr is the last word
module ram8_bist_addr_ctr
  import ram8_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (en) begin
      // Natural wrap from the last word to 0 gives the phase-change rewind.
      addr <= addr + 1'b1;
    end
  end

  assign tc = (addr == {ADDR_W{1'b1}});

endmodule

// File: rtl/ram8_bist.sv
// ram8_bist
// Four-phase pattern test engine for one RAM8:
//   W0 writes PATTERN to every word, R0 checks it, W1 writes ~PATTERN,
//   R1 checks it. The first mismatching address and read value are kept.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a test (only looked at in IDLE)
//   mem         : master side of ram8_bist_if (mem_in/mem_load/mem_address
//                 out, mem_out in)
//   busy        : high for the 32 cycles of W0..R1
//   done        : one-cycle pulse when the test ends
//   pass        : result, valid from done until the next start
//   fail_addr   : address of the first mismatch
//   fail_data   : mem_out value seen at the first mismatch
//   dbg_state   : current FSM state, for observation only
// Optional feature: define RAM8_BIST_STOP_ON_FAIL_EN to end the test on the
// first read mismatch (DONE on that same edge, remaining phases skipped).
// Without it all four phases always run.
module ram8_bist
  import ram8_bist_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEF,
  parameter int               ADDR_W  = ADDR_W_DEF,
  parameter logic [WIDTH-1:0] PATTERN = PATTERN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  ram8_bist_if.master       mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_data,
  output state_t            dbg_state
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr;
  logic              tc;
  logic              ctr_clr;
  logic              ctr_en;
  logic [WIDTH-1:0]  exp_data;
  logic              mismatch;
  logic              fail_flag;

  // The counter output is itself a register, so mem_address stays registered.
  ram8_bist_addr_ctr #(
    .ADDR_W (ADDR_W)
  ) u_addr_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .addr  (addr),
    .tc    (tc)
  );

  // Held at 0 outside the test so every run starts W0 at word 0.
  assign ctr_clr = (state_q == IDLE) || (state_q == DONE);
  assign ctr_en  = is_busy_state(state_q);

  assign mem.mem_address = addr;
  assign dbg_state       = state_q;

  // Compare is exact over the full word; only meaningful in read phases.
  assign exp_data = (state_q == R1) ? ~PATTERN : PATTERN;
  assign mismatch = ((state_q == R0) || (state_q == R1)) &&
                    (mem.mem_out != exp_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = W0;
      W0:   if (tc) state_d = R0;
`ifdef RAM8_BIST_STOP_ON_FAIL_EN
      R0: begin
        if (mismatch)  state_d = DONE;
        else if (tc)   state_d = W1;
      end
`else
      R0:   if (tc) state_d = W1;
`endif
      W1:   if (tc) state_d = R1;
`ifdef RAM8_BIST_STOP_ON_FAIL_EN
      R1:   if (mismatch || tc) state_d = DONE;
`else
      R1:   if (tc) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are loaded from the next state so they line up with the state
  // they describe while still coming straight out of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_in   <= '0;
      mem.mem_load <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_addr    <= '0;
      fail_data    <= '0;
      fail_flag    <= 1'b0;
    end else begin
      busy         <= is_busy_state(state_d);
      done         <= (state_d == DONE);
      mem.mem_load <= (state_d == W0) || (state_d == W1);

      // Read phases keep the pattern of the write phase before them.
      if (state_d == W0) begin
        mem.mem_in <= PATTERN;
      end else if (state_d == W1) begin
        mem.mem_in <= ~PATTERN;
      end

      if ((state_q == IDLE) && start) begin
        pass      <= 1'b0;
        fail_flag <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (mismatch && !fail_flag) begin
        fail_flag <= 1'b1;
        fail_addr <= addr;
        fail_data <= mem.mem_out;
      end

      // Include a mismatch seen on this very edge (last R1 word, or the
      // early exit when stopping on fail).
      if (state_d == DONE) begin
        pass <= !(fail_flag || mismatch);
      end
    end
  end

endmodule

// File: tb/tb_ram8_bist.sv
// tb_ram8_bist
// Bench for ram8_bist: behavioural RAM8 with an injectable stuck-at fault,
// a result model computed from the test rules, an expected queue for the
// per-cycle write/address sequence, and a one-line final report.
module tb_ram8_bist;
  import ram8_bist_pkg::*;

  localparam logic [15:0] PAT   = 16'h5555;
  localparam logic [15:0] PAT_N = 16'hAAAA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic        busy, done, pass;
  logic [2:0]  fail_addr;
  logic [15:0] fail_data;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;

  ram8_bist_if #(.WIDTH(16), .ADDR_W(3)) mem_if ();

  ram8_bist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem       (mem_if.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .dbg_state (dbg_state)
  );

  // ---------------- RAM8 model with fault ----------------
  logic [15:0] ram [8];
  bit          fault_en = 1'b0;
  int          fault_addr = 0;
  logic [15:0] sa0_mask = '0;
  logic [15:0] sa1_mask = '0;
  logic [15:0] rd_word;

  always @(posedge clk) begin
    if (mem_if.mem_load) ram[mem_if.mem_address] <= mem_if.mem_in;
  end

  assign rd_word = ram[mem_if.mem_address];
  assign mem_if.mem_out = (fault_en && (int'(mem_if.mem_address) == fault_addr))
                          ? ((rd_word & ~sa0_mask) | sa1_mask) : rd_word;

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input int a, input logic [15:0] stored);
    if (fault_en && a == fault_addr) return (stored & ~sa0_mask) | sa1_mask;
    return stored;
  endfunction

  // Walk the four phases at word level: find the first word whose read-back
  // differs from what was written, and derive the busy length from it.
  task automatic model_expect(output bit e_pass, output int e_fa,
                              output logic [15:0] e_fd, output int e_busy);
    bit found = 1'b0;
    logic [15:0] pat, seen;
    e_pass = 1'b1; e_fa = 0; e_fd = '0; e_busy = 32;
    for (int ph = 0; ph < 2; ph++) begin
      pat = (ph == 0) ? PAT : PAT_N;
      for (int a = 0; a < 8; a++) begin
        seen = model_read(a, pat);
        if (!found && seen != pat) begin
          found = 1'b1; e_pass = 1'b0; e_fa = a; e_fd = seen;
`ifdef RAM8_BIST_STOP_ON_FAIL_EN
          e_busy = 16 * ph + 8 + a + 1;
`endif
        end
      end
    end
    exp_q.delete();
    for (int k = 0; k < e_busy; k++) begin
      logic       l;
      logic [2:0] a3;
      l  = ((k / 8) % 2) == 0;
      a3 = 3'(k % 8);
      exp_q.push_back({l, a3, (k < 16) ? PAT : PAT_N});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_test(input string name, input bit hold_start, input int glitch_cycle);
    bit          e_pass;
    int          e_fa, e_busy;
    logic [15:0] e_fd;
    int          busy_cnt = 0;
    int          done_n = 0;
    logic [19:0] exp_e;
    model_expect(e_pass, e_fa, e_fd, e_busy);
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= 100 && done_n == 0; n++) begin
      @(negedge clk);
      if (!hold_start) start = (n == glitch_cycle);
      if (busy) begin
        busy_cnt++;
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check({name, " seq"}, {12'd0, mem_if.mem_load, mem_if.mem_address, mem_if.mem_in},
                {12'd0, exp_e});
        end else begin
          check({name, " seq_extra"}, busy_cnt, e_busy);
        end
      end
      if (done) done_n = n;
    end
    if (!hold_start) start = 1'b0;
    check({name, " done_seen"}, 32'(done_n != 0), 1);
    check({name, " busy_cycles"}, busy_cnt, e_busy);
    check({name, " done_cycle"}, done_n, e_busy + 1);
    check({name, " pass"}, pass, e_pass);
    check({name, " fail_addr"}, fail_addr, e_fa);
    check({name, " fail_data"}, fail_data, e_fd);
    check({name, " seq_short"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check({name, " done_pulse"}, done, 0);
    check({name, " pass_hold"}, pass, e_pass);
    check({name, " idle_busy"}, busy, 0);
  endtask

  task automatic set_fault(input bit en, input int a, input int b, input bit sa1);
    fault_en = en; fault_addr = a;
    sa0_mask = '0; sa1_mask = '0;
    if (sa1) sa1_mask[b] = 1'b1;
    else     sa0_mask[b] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    int dones;
    // Reset with start asserted: nothing may move.
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst mem_load", mem_if.mem_load, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst mem_address", mem_if.mem_address, 0);
    check("rst mem_in", mem_if.mem_in, 0);
    check("rst fail_addr", fail_addr, 0);
    check("rst fail_data", fail_data, 0);
    check("rst state", dbg_state, IDLE);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Fault-free run; RAM must end up holding the inverse pattern.
    set_fault(1'b0, 0, 0, 1'b0);
    run_test("clean", 1'b0, -1);
    for (int i = 0; i < 8; i++) check($sformatf("ram_final[%0d]", i), ram[i], PAT_N);

    // Directed faults.
    set_fault(1'b1, 3, 0, 1'b0);
    run_test("a3_b0_sa0", 1'b0, -1);
    set_fault(1'b1, 6, 0, 1'b1);
    run_test("a6_b0_sa1", 1'b0, -1);
    set_fault(1'b1, 6, 1, 1'b1);
    run_test("a6_b1_sa1", 1'b0, -1);

    // start pulse mid-test must be ignored.
    set_fault(1'b0, 0, 0, 1'b0);
    run_test("glitch", 1'b0, 10);

    // start held through DONE: restart right after IDLE, pass cleared.
    run_test("hold", 1'b1, -1);
    @(negedge clk);
    check("hold restart_busy", busy, 1);
    check("hold restart_pass_clear", pass, 0);
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 100) begin @(negedge clk); cnt++; end
    check("hold second_done", 32'(cnt < 100), 1);
    check("hold second_pass", pass, 1);
    @(negedge clk);

    // Reset in the middle of W1 at address 5.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    for (int n = 0; n < 60 && cnt < 22; n++) begin
      if (busy) cnt++;
      if (cnt < 22) @(negedge clk);
    end
    check("midrst reached", cnt, 22);
    check("midrst addr", mem_if.mem_address, 5);
    check("midrst load_before", mem_if.mem_load, 1);
    rst_n = 1'b0;
    #1;
    check("midrst load_async", mem_if.mem_load, 0);
    check("midrst busy_async", busy, 0);
    check("midrst state", dbg_state, IDLE);
    check("midrst pass", pass, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    check("midrst no_done", dones, 0);
    check("midrst still_idle", busy, 0);
    run_test("after_reset", 1'b0, -1);

    // Randomized faults and idle gaps.
    for (int r = 0; r < 8; r++) begin
      set_fault($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_test($sformatf("rand%0d", r), 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
